// File: rtl/onchip_sram_arb_pkg.sv
// Shared types and defaults for the two-master on-chip SRAM port arbiter.
// Holds the ownership state encoding, read-return tag and hold-count helper.
package onchip_sram_arb_pkg;

    localparam int DEF_ADDR_W = 14;
    localparam int DEF_DATA_W = 32;
    localparam int HOLD_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic valid;
        logic owner;
    } ret_tag_t;

    // Consecutive-grant counter never exceeds the hold limit.
    function automatic logic [HOLD_W-1:0] hold_sat_inc(
        input logic [HOLD_W-1:0] cnt,
        input logic [HOLD_W-1:0] max_hold
    );
        logic [HOLD_W-1:0] res;
        if (cnt >= max_hold) begin
            res = max_hold;
        end else begin
            res = cnt + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/onchip_sram_port_arbiter.sv
// Two-master arbiter onto a single-port on-chip SRAM with bounded hold fairness.
// Commands are granted combinationally; read data returns one cycle later tagged to its owner.
module onchip_sram_port_arbiter
    import onchip_sram_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_HOLD = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     sram_address,
    output logic                  sram_chipselect,
    output logic                  sram_write,
    output logic [DATA_W/8-1:0]   sram_byteenable,
    output logic [DATA_W-1:0]     sram_writedata,
    output logic                  sram_clken,
    input  logic [DATA_W-1:0]     sram_readdata
);

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

    arb_state_t        state_r;
    arb_state_t        state_nxt_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_nxt_s;
    logic              last_served_r;
    logic              last_nxt_s;
    ret_tag_t          ret_r;
    ret_tag_t          ret_nxt_s;

    logic              req0_s;
    logic              req1_s;
    logic              grant0_s;
    logic              grant1_s;
    logic              rd_grant_s;

    // Grant selection: a lone requester always wins; contention uses ownership and hold limit.
    always_comb begin
        req0_s   = m0_read | m0_write;
        req1_s   = m1_read | m1_write;
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (reset) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (req0_s && req1_s) begin
            case (state_r)
                OWN0: begin
                    if (hold_cnt_r < MAX_HOLD_C) begin
                        grant0_s = 1'b1;
                    end else begin
                        grant1_s = 1'b1;
                    end
                end
                OWN1: begin
                    if (hold_cnt_r < MAX_HOLD_C) begin
                        grant1_s = 1'b1;
                    end else begin
                        grant0_s = 1'b1;
                    end
                end
                default: begin
                    if (last_served_r) begin
                        grant0_s = 1'b1;
                    end else begin
                        grant1_s = 1'b1;
                    end
                end
            endcase
        end else if (req0_s) begin
            grant0_s = 1'b1;
        end else if (req1_s) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Next ownership, hold count and last-served bookkeeping.
    always_comb begin
        state_nxt_s = IDLE;
        hold_nxt_s  = 4'd0;
        last_nxt_s  = last_served_r;
        if (grant0_s) begin
            state_nxt_s = OWN0;
            last_nxt_s  = 1'b0;
            if (state_r == OWN0) begin
                hold_nxt_s = hold_sat_inc(hold_cnt_r, MAX_HOLD_C);
            end else begin
                hold_nxt_s = 4'd1;
            end
        end else if (grant1_s) begin
            state_nxt_s = OWN1;
            last_nxt_s  = 1'b1;
            if (state_r == OWN1) begin
                hold_nxt_s = hold_sat_inc(hold_cnt_r, MAX_HOLD_C);
            end else begin
                hold_nxt_s = 4'd1;
            end
        end else begin
            state_nxt_s = IDLE;
            hold_nxt_s  = 4'd0;
        end
    end

    // Read-return tag: read+write together counts as a write, so only pure reads return data.
    always_comb begin
        rd_grant_s      = (grant0_s & m0_read & ~m0_write) | (grant1_s & m1_read & ~m1_write);
        ret_nxt_s.valid = rd_grant_s;
        ret_nxt_s.owner = grant1_s;
    end

    // Arbiter state and return-tag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            hold_cnt_r    <= 4'd0;
            last_served_r <= 1'b1;
            ret_r         <= '0;
        end else begin
            state_r       <= state_nxt_s;
            hold_cnt_r    <= hold_nxt_s;
            last_served_r <= last_nxt_s;
            ret_r         <= ret_nxt_s;
        end
    end

    // Master-facing handshake and SRAM command mux.
    always_comb begin
        m0_waitrequest   = reset | (req0_s & ~grant0_s);
        m1_waitrequest   = reset | (req1_s & ~grant1_s);
        m0_readdata      = sram_readdata;
        m1_readdata      = sram_readdata;
        m0_readdatavalid = ret_r.valid & ~ret_r.owner & ~reset;
        m1_readdatavalid = ret_r.valid &  ret_r.owner & ~reset;
        sram_chipselect  = grant0_s | grant1_s;
        sram_write       = (grant0_s & m0_write) | (grant1_s & m1_write);
        sram_clken       = 1'b1;
        if (grant1_s) begin
            sram_address    = m1_address;
            sram_byteenable = m1_byteenable;
            sram_writedata  = m1_writedata;
        end else begin
            sram_address    = m0_address;
            sram_byteenable = m0_byteenable;
            sram_writedata  = m0_writedata;
        end
    end

endmodule

// File: tb/tb_onchip_sram_port_arbiter.sv
// Directed self-checking bench for onchip_sram_port_arbiter with a behavioural SRAM model.
module tb_onchip_sram_port_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [3:0]        m0_byteenable, m1_byteenable;
    logic [DATA_W-1:0] m0_writedata, m1_writedata;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] sram_address;
    logic              sram_chipselect, sram_write, sram_clken;
    logic [3:0]        sram_byteenable;
    logic [DATA_W-1:0] sram_writedata;
    logic [DATA_W-1:0] sram_readdata;

    logic [DATA_W-1:0] mem [0:16383];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    onchip_sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(4)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .sram_address(sram_address), .sram_chipselect(sram_chipselect),
        .sram_write(sram_write), .sram_byteenable(sram_byteenable),
        .sram_writedata(sram_writedata), .sram_clken(sram_clken),
        .sram_readdata(sram_readdata)
    );

    // Synchronous SRAM: byte-enabled writes, read data registered one cycle.
    always @(posedge clk) begin
        if (sram_chipselect && sram_clken) begin
            if (sram_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_byteenable[b]) mem[sram_address][8*b +: 8] <= sram_writedata[8*b +: 8];
                end
            end else begin
                sram_readdata <= mem[sram_address];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    endtask

    initial begin
        int owner, prev_owner;
        logic [31:0] exp_d;
        reset = 1'b1;
        m0_address = 14'd0; m1_address = 14'd0;
        m0_byteenable = 4'hF; m1_byteenable = 4'hF;
        m0_writedata = 32'd0; m1_writedata = 32'd0;
        sram_readdata = 32'd0;
        m0_read = 1'b1; m0_write = 1'b0; m1_read = 1'b1; m1_write = 1'b1;
        cyc(); cyc();
        check_eq("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
        check_eq("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
        check_eq("rst_cs", 32'(sram_chipselect), 32'd0);
        check_eq("rst_wr", 32'(sram_write), 32'd0);
        check_eq("rst_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 32'd0);
        check_eq("clken", 32'(sram_clken), 32'd1);

        // m0 alone: write then read back, first grant right after reset release
        reset = 1'b0; idle_inputs();
        m0_write = 1'b1; m0_address = 14'h0010; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
        #1;
        check_eq("w_m0_wait", 32'(m0_waitrequest), 32'd0);
        check_eq("w_cs", 32'(sram_chipselect), 32'd1);
        check_eq("w_sram_wr", 32'(sram_write), 32'd1);
        check_eq("w_addr", 32'(sram_address), 32'h10);
        cyc();
        m0_write = 1'b0; m0_read = 1'b1;
        #1;
        check_eq("r_m0_wait", 32'(m0_waitrequest), 32'd0);
        check_eq("r_sram_wr", 32'(sram_write), 32'd0);
        check_eq("w_no_rdv", 32'(m0_readdatavalid), 32'd0);
        cyc();
        m0_read = 1'b0;
        check_eq("r_m0_rdv", 32'(m0_readdatavalid), 32'd1);
        check_eq("r_m1_rdv", 32'(m1_readdatavalid), 32'd0);
        check_eq("r_data", m0_readdata, 32'hDEADBEEF);
        cyc();
        check_eq("r_rdv_once", 32'(m0_readdatavalid), 32'd0);

        // Both read continuously from reset: blocks of four grants each
        reset = 1'b1; cyc(); reset = 1'b0;
        m0_read = 1'b1; m1_read = 1'b1; m0_address = 14'h0010; m1_address = 14'h0020;
        prev_owner = -1;
        for (int k = 0; k < 16; k++) begin
            owner = (k / 4) % 2;
            #1;
            check_eq($sformatf("hold_m0_wait_%0d", k), 32'(m0_waitrequest), 32'(owner == 1));
            check_eq($sformatf("hold_m1_wait_%0d", k), 32'(m1_waitrequest), 32'(owner == 0));
            if (prev_owner >= 0) begin
                check_eq($sformatf("hold_m0_rdv_%0d", k), 32'(m0_readdatavalid), 32'(prev_owner == 0));
                check_eq($sformatf("hold_m1_rdv_%0d", k), 32'(m1_readdatavalid), 32'(prev_owner == 1));
            end
            prev_owner = owner;
            cyc();
        end
        idle_inputs();
        cyc();

        // Alternating single reads from two preloaded words
        m0_write = 1'b1; m0_address = 14'h0001; m0_writedata = 32'h11; cyc();
        m0_address = 14'h0002; m0_writedata = 32'h22; cyc();
        m0_write = 1'b0;
        for (int k = 0; k < 7; k++) begin
            idle_inputs();
            if (k < 6) begin
                if (k % 2 == 0) begin m0_read = 1'b1; m0_address = 14'h0001; end
                else begin m1_read = 1'b1; m1_address = 14'h0002; end
            end
            #1;
            if (k < 6) begin
                check_eq($sformatf("alt_wait_%0d", k), 32'({m0_waitrequest, m1_waitrequest}), 32'd0);
            end
            if (k > 0) begin
                exp_d = (k % 2 == 1) ? 32'h11 : 32'h22;
                check_eq($sformatf("alt_m0_rdv_%0d", k), 32'(m0_readdatavalid), 32'(k % 2 == 1));
                check_eq($sformatf("alt_m1_rdv_%0d", k), 32'(m1_readdatavalid), 32'(k % 2 == 0));
                check_eq($sformatf("alt_data_%0d", k), (k % 2 == 1) ? m0_readdata : m1_readdata, exp_d);
            end
            cyc();
        end
        idle_inputs();

        // Simultaneous writes to the top address: m0 first, m1 next, m1 data survives
        reset = 1'b1; cyc(); reset = 1'b0;
        m0_write = 1'b1; m0_address = 14'h3FFF; m0_writedata = 32'hAAAA5555;
        m1_write = 1'b1; m1_address = 14'h3FFF; m1_writedata = 32'h12345678;
        #1;
        check_eq("ww_m0_wait", 32'(m0_waitrequest), 32'd0);
        check_eq("ww_m1_wait", 32'(m1_waitrequest), 32'd1);
        check_eq("ww_wdata0", sram_writedata, 32'hAAAA5555);
        cyc();
        m0_write = 1'b0;
        #1;
        check_eq("ww_m1_wait2", 32'(m1_waitrequest), 32'd0);
        check_eq("ww_wdata1", sram_writedata, 32'h12345678);
        check_eq("ww_no_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 32'd0);
        cyc();
        m1_write = 1'b0; m0_read = 1'b1; m0_address = 14'h3FFF;
        cyc();
        m0_read = 1'b0;
        check_eq("ww_rb_rdv", 32'(m0_readdatavalid), 32'd1);
        check_eq("ww_final", m0_readdata, 32'h12345678);
        cyc();

        // Reset in the cycle an m1 read is presented, with a pending m0 return
        m0_read = 1'b1; m0_address = 14'h0001; cyc();
        m0_read = 1'b0; m1_read = 1'b1; m1_address = 14'h0002; reset = 1'b1;
        #1;
        check_eq("rr_m1_wait", 32'(m1_waitrequest), 32'd1);
        check_eq("rr_m0_rdv_in_rst", 32'(m0_readdatavalid), 32'd0);
        cyc();
        reset = 1'b0; m1_read = 1'b0;
        #1;
        check_eq("rr_no_m1_rdv", 32'(m1_readdatavalid), 32'd0);
        m0_read = 1'b1; m1_read = 1'b1;
        #1;
        check_eq("rr_m0_first", 32'(m0_waitrequest), 32'd0);
        check_eq("rr_m1_waits", 32'(m1_waitrequest), 32'd1);
        cyc();
        idle_inputs();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/onchip_sram_port_arbiter.md
ONCHIP_SRAM_PORT_ARBITER -- requirements
Module: onchip_sram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14: word address width (16384 x 32 on-chip SRAM).
REQ-002 SHALL have parameter DATA_W, default 32: data width; byteenable width = DATA_W/8.
REQ-003 SHALL have parameter MAX_HOLD, default 4: maximum consecutive grants to one master while the other is waiting; legal range 1..15.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have ports m<i>_address, input, ADDR_W (i = 0,1): master i word address.
REQ-007 SHALL have ports m<i>_read, input, 1; and m<i>_write, input, 1: master i read/write strobes.
REQ-008 SHALL have ports m<i>_byteenable, input, DATA_W/8; and m<i>_writedata, input, DATA_W.
REQ-009 SHALL have ports m<i>_waitrequest, output, 1: command not accepted this cycle.
REQ-010 SHALL have ports m<i>_readdata, output, DATA_W; and m<i>_readdatavalid, output, 1.
REQ-011 SHALL have SRAM-side outputs sram_address (ADDR_W), sram_chipselect, sram_write, sram_byteenable, sram_writedata, sram_clken (1 each unless noted).
REQ-012 SHALL have sram_readdata, input, DATA_W: unregistered SRAM port output, valid one cycle after the read is presented.

Function
REQ-013 A master requests when read or write is high; read and write together SHALL be treated as write.
REQ-014 FSM states IDLE, OWN0, OWN1; state = master granted in the previous cycle (IDLE = none).
REQ-015 Only one master requesting: that master SHALL be granted in the same cycle, regardless of state.
REQ-016 Both requesting in IDLE: grant goes to the master not served last (last_served resets to 1, so m0 wins first).
REQ-017 Both requesting in OWNi: master i keeps the grant while hold_cnt < MAX_HOLD, else grant SHALL switch to the other master.
REQ-018 hold_cnt SHALL count consecutive grants to the current owner, reset to 1 on an ownership change, saturate at MAX_HOLD.
REQ-019 No requests: next state IDLE, hold_cnt cleared, last_served retained.
REQ-020 m<i>_waitrequest = request_i AND NOT grant_i, combinational; a granted command is accepted in that cycle.
REQ-021 Granted master's address, byteenable, writedata SHALL be muxed combinationally to the SRAM; sram_chipselect = any grant; sram_write = granted write.
REQ-022 sram_clken SHALL be constant 1.
REQ-023 A granted read SHALL set a one-deep return register {valid, owner}; next cycle m<owner>_readdatavalid = 1, exactly one cycle, zero added latency (total read latency 1).
REQ-024 Both m<i>_readdata SHALL carry sram_readdata; readdatavalid alone qualifies data.
REQ-025 Back-to-back reads, including alternating masters, SHALL sustain one per cycle with correct owner tagging.
REQ-026 Writes produce no readdatavalid.

Reset
REQ-027 While reset is high: state IDLE, hold_cnt 0, last_served 1, return register invalid; outputs m<i>_waitrequest 1, sram_chipselect 0, sram_write 0, m<i>_readdatavalid 0.
REQ-028 A read granted in the cycle reset asserts SHALL NOT produce readdatavalid after reset.
REQ-029 First grant is possible in the first cycle after reset deasserts.

Structure
REQ-030 Package onchip_sram_arb_pkg SHALL hold the state enum (IDLE/OWN0/OWN1), default ADDR_W/DATA_W constants, and the return-tag struct {valid, owner}.
REQ-031 Single flat module, no sub-module; target 150-250 lines of RTL.

Verification
REQ-032 m0 alone: write 0xDEADBEEF to 0x0010 (be=0xF), then read 0x0010 -> waitrequest never high, m0_readdatavalid one cycle after the read with 0xDEADBEEF.
REQ-033 Both masters read continuously from reset, MAX_HOLD=4 -> grants m0 x4, m1 x4, m0 x4...; m1_waitrequest high exactly while m0 owns.
REQ-034 Alternating single reads m0@0x0001 / m1@0x0002 holding 0x11 / 0x22 -> each readdatavalid on the correct master, correct data, no bubbles.
REQ-035 Both write to 0x3FFF same cycle from IDLE after reset -> m0 first, m1 next cycle; final content = m1 data.
REQ-036 Assert reset in the cycle an m1 read is granted -> no m1_readdatavalid; after release, both requesting -> m0 granted first.
